// File: rtl/vpifo_pkg.sv
// Shared vPIFO definitions: task opcodes and task-entry layout.
// Entry layout (MSB..LSB): {type, tree_id, payload}; the distributor decodes the same offsets.
package vpifo_pkg;

    localparam logic TASK_PUSH = 1'b1;
    localparam logic TASK_POP  = 1'b0;

    // Total entry width: payload + tree id + one type bit.
    function automatic int unsigned task_entry_w(input int unsigned ptw,
                                                 input int unsigned mtw,
                                                 input int unsigned tnb);
        return ptw + mtw + tnb + 1;
    endfunction

    // Payload occupies the low bits.
    function automatic int unsigned task_data_lsb();
        return 0;
    endfunction

    // Tree id sits directly above the payload.
    function automatic int unsigned task_tree_lsb(input int unsigned ptw,
                                                  input int unsigned mtw);
        return ptw + mtw;
    endfunction

    // Type bit is the entry MSB.
    function automatic int unsigned task_type_bit(input int unsigned ptw,
                                                  input int unsigned mtw,
                                                  input int unsigned tnb);
        return ptw + mtw + tnb;
    endfunction

endpackage

// File: rtl/task_fifo.sv
// Synchronous FIFO with registered read data and count-based full/empty flags.
// A read on an empty FIFO is ignored and the output register holds its value.
module task_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rdata_q;
    logic             wr_en, rd_en;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_rdata = rdata_q;

    // Writes into a full FIFO and reads from an empty one are suppressed here.
    assign wr_en = i_wr && !o_full;
    assign rd_en = i_rd && !o_empty;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and registered read port; reset wipes contents too.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= i_wdata;
            end
            // With count == 1 the write slot differs from the head, so the old head is read.
            if (rd_en) begin
                rdata_q <= mem_q[rd_ptr_q];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/task_fifo_bank.sv
// Write side of the per-level task FIFOs: packs host requests into task entries and deals
// them round-robin over LEVEL FIFOs. A full target FIFO stalls the host (no skipping).
// Optional per-tree occupancy check: define TASK_FIFO_BANK_TREE_CHECK_EN.
module task_fifo_bank
    import vpifo_pkg::*;
#(
    parameter int unsigned PTW           = 16,
    parameter int unsigned MTW           = 16,
    parameter int unsigned LEVEL         = 4,
    parameter int unsigned TREE_NUM      = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned TREE_CAP      = 8,
    localparam int unsigned LEVEL_BITS    = (LEVEL > 1) ? $clog2(LEVEL) : 1,
    localparam int unsigned TREE_NUM_BITS = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
    localparam int unsigned ENTRY_W       = task_entry_w(PTW, MTW, TREE_NUM_BITS)
) (
    input  logic                            i_clk,
    input  logic                            i_arst_n,
    input  logic                            i_valid,
    input  logic                            i_type,
    input  logic [TREE_NUM_BITS-1:0]        i_tree_id,
    input  logic [PTW+MTW-1:0]              i_push_data,
    output logic                            o_ready,
    output logic                            o_drop,
    input  logic [LEVEL-1:0]                i_pop_TaskFIFO,
    output logic [LEVEL-1:0][ENTRY_W-1:0]   o_TaskFIFO_data,
    output logic [LEVEL-1:0]                o_TaskFIFO_empty
);

    localparam int unsigned DATA_LSB = task_data_lsb();
    localparam int unsigned TREE_LSB = task_tree_lsb(PTW, MTW);
    localparam int unsigned TYPE_BIT = task_type_bit(PTW, MTW, TREE_NUM_BITS);

    if ((FIFO_DEPTH == 0) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a non-zero power of two");
    end
    if (TREE_CAP == 0) begin : g_bad_cap
        $error("TREE_CAP must be at least 1");
    end

    logic                  init_q;
    logic [LEVEL_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [LEVEL-1:0]      full;
    logic [LEVEL-1:0]      wr_vec;
    logic [ENTRY_W-1:0]    entry;
    logic                  accept;
    logic                  drop;
    logic                  wr_en;

    // init_q keeps o_ready low until the first edge after reset release.
    assign o_ready = init_q && !full[rr_ptr_q];
    assign accept  = i_valid && o_ready;
    assign wr_en   = accept && !drop;

    // Pack the request; pops carry a zero payload.
    always_comb begin
        entry                                = '0;
        entry[TYPE_BIT]                      = i_type;
        entry[TREE_LSB +: TREE_NUM_BITS]     = i_tree_id;
        entry[DATA_LSB +: PTW+MTW]           = (i_type == TASK_PUSH) ? i_push_data : '0;
    end

    // Steer the write to the current round-robin target and advance the pointer.
    always_comb begin
        wr_vec   = '0;
        rr_ptr_d = rr_ptr_q;
        if (wr_en) begin
            wr_vec[rr_ptr_q] = 1'b1;
            rr_ptr_d = (rr_ptr_q == LEVEL_BITS'(LEVEL - 1)) ? '0 : rr_ptr_q + 1'b1;
        end
    end

    // Ready qualifier and round-robin pointer state.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            init_q   <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            init_q   <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef TASK_FIFO_BANK_TREE_CHECK_EN
    localparam int unsigned TCW = $clog2(TREE_CAP + 1);

    logic [TCW-1:0] tree_cnt_q [TREE_NUM];
    logic [TCW-1:0] cnt_sel;
    logic           drop_q;

    assign cnt_sel = tree_cnt_q[i_tree_id];
    assign o_drop  = drop_q;

    // A push into a saturated tree or a pop from an empty tree is consumed but discarded.
    always_comb begin
        drop = 1'b0;
        if (accept) begin
            if (i_type == TASK_PUSH) begin
                drop = (cnt_sel == TCW'(TREE_CAP));
            end else begin
                drop = (cnt_sel == '0);
            end
        end
    end

    // Per-tree occupancy counters and the registered drop pulse.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int t = 0; t < int'(TREE_NUM); t++) begin
                tree_cnt_q[t] <= '0;
            end
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop;
            if (wr_en) begin
                if (i_type == TASK_PUSH) begin
                    tree_cnt_q[i_tree_id] <= cnt_sel + 1'b1;
                end else begin
                    tree_cnt_q[i_tree_id] <= cnt_sel - 1'b1;
                end
            end
        end
    end
`else
    assign drop   = 1'b0;
    assign o_drop = 1'b0;
`endif

    for (genvar g = 0; g < int'(LEVEL); g++) begin : g_fifo
        task_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_task_fifo (
            .i_clk   (i_clk),
            .i_arst_n(i_arst_n),
            .i_wr    (wr_vec[g]),
            .i_wdata (entry),
            .i_rd    (i_pop_TaskFIFO[g]),
            .o_rdata (o_TaskFIFO_data[g]),
            .o_full  (full[g]),
            .o_empty (o_TaskFIFO_empty[g])
        );
    end

endmodule

// File: tb/tb_task_fifo_bank.sv
// Directed bench for task_fifo_bank with default parameters.
// Expectations follow TASK_FIFO_BANK_TREE_CHECK_EN when it is defined for the build.
module tb_task_fifo_bank;

    localparam int W = 35;

    logic                i_clk = 1'b0;
    logic                i_arst_n = 1'b0;
    logic                i_valid = 1'b0;
    logic                i_type = 1'b0;
    logic [1:0]          i_tree_id = '0;
    logic [31:0]         i_push_data = '0;
    logic                o_ready;
    logic                o_drop;
    logic [3:0]          i_pop_TaskFIFO = '0;
    logic [3:0][W-1:0]   o_TaskFIFO_data;
    logic [3:0]          o_TaskFIFO_empty;

    int n_checks = 0;
    int n_errors = 0;

    task_fifo_bank u_dut (
        .i_clk           (i_clk),
        .i_arst_n        (i_arst_n),
        .i_valid         (i_valid),
        .i_type          (i_type),
        .i_tree_id       (i_tree_id),
        .i_push_data     (i_push_data),
        .o_ready         (o_ready),
        .o_drop          (o_drop),
        .i_pop_TaskFIFO  (i_pop_TaskFIFO),
        .o_TaskFIFO_data (o_TaskFIFO_data),
        .o_TaskFIFO_empty(o_TaskFIFO_empty)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic t, input logic [1:0] tr, input logic [31:0] d);
        return {t, tr, d};
    endfunction

    task automatic cyc();
        @(negedge i_clk);
    endtask

    // One request held for one edge; all stimulus changes on the falling edge.
    task automatic do_req(input logic t, input logic [1:0] tr, input logic [31:0] d);
        i_valid = 1'b1;
        i_type = t;
        i_tree_id = tr;
        i_push_data = d;
        cyc();
        i_valid = 1'b0;
    endtask

    task automatic do_pop(input int idx);
        i_pop_TaskFIFO = 4'(1 << idx);
        cyc();
        i_pop_TaskFIFO = '0;
    endtask

    task automatic do_reset(input string tag);
        i_valid = 1'b0;
        i_pop_TaskFIFO = '0;
        i_arst_n = 1'b0;
        cyc();
        check_eq({tag, "_rst_empty"}, 64'(o_TaskFIFO_empty), 64'hF);
        check_eq({tag, "_rst_ready"}, 64'(o_ready), 64'h0);
        check_eq({tag, "_rst_drop"}, 64'(o_drop), 64'h0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_rst_data%0d", tag, i), 64'(o_TaskFIFO_data[i]), 64'h0);
        end
        i_arst_n = 1'b1;
        check_eq({tag, "_rel_ready0"}, 64'(o_ready), 64'h0);
        cyc();
        check_eq({tag, "_rel_ready1"}, 64'(o_ready), 64'h1);
    endtask

    initial begin
        int exp_idx;
        logic [W-1:0] exp_e;
        cyc();

        // 1: reset and release
        do_reset("t1");

        // 2: four pushes on tree 2 deal one per FIFO
        for (int k = 1; k <= 4; k++) begin
            do_req(1'b1, 2'd2, 32'(k));
        end
        check_eq("t2_empty", 64'(o_TaskFIFO_empty), 64'h0);
        do_pop(1);
        check_eq("t2_data1", 64'(o_TaskFIFO_data[1]), 64'(mk(1'b1, 2'd2, 32'h2)));
        check_eq("t2_empty1", 64'(o_TaskFIFO_empty), 64'h2);

        // 3: pop on an empty tree; mid-operation reset first
        do_reset("t3");
        do_req(1'b0, 2'd3, 32'h0);
`ifdef TASK_FIFO_BANK_TREE_CHECK_EN
        check_eq("t3_drop", 64'(o_drop), 64'h1);
        check_eq("t3_empty", 64'(o_TaskFIFO_empty), 64'hF);
`else
        check_eq("t3_drop", 64'(o_drop), 64'h0);
        check_eq("t3_empty", 64'(o_TaskFIFO_empty), 64'hE);
`endif
        do_req(1'b1, 2'd1, 32'h55);
        check_eq("t3_drop_clr", 64'(o_drop), 64'h0);
`ifdef TASK_FIFO_BANK_TREE_CHECK_EN
        check_eq("t3_empty2", 64'(o_TaskFIFO_empty), 64'hE);
        exp_e = mk(1'b1, 2'd1, 32'h55);
        exp_idx = 1;
`else
        check_eq("t3_empty2", 64'(o_TaskFIFO_empty), 64'hC);
        exp_e = mk(1'b0, 2'd3, 32'h0);
        exp_idx = 2;
`endif
        do_pop(0);
        check_eq("t3_fifo0", 64'(o_TaskFIFO_data[0]), 64'(exp_e));
        // Pop with a non-zero payload on the bus: stored payload must be zero.
        do_req(1'b0, 2'd1, 32'hDEAD_BEEF);
        check_eq("t3_pop_drop", 64'(o_drop), 64'h0);
        do_pop(exp_idx);
        check_eq("t3_pop_entry", 64'(o_TaskFIFO_data[exp_idx]), 64'(mk(1'b0, 2'd1, 32'h0)));

        // 4: fill all FIFOs, stall, free a slot in FIFO0
        do_reset("t4");
        for (int k = 0; k < 16; k++) begin
            check_eq($sformatf("t4_ready%0d", k), 64'(o_ready), 64'h1);
            do_req(1'b1, 2'(k / 4), 32'(k));
        end
        check_eq("t4_full_ready", 64'(o_ready), 64'h0);
        i_valid = 1'b1;
        i_type = 1'b1;
        i_tree_id = 2'd0;
        i_push_data = 32'h11;
        cyc();
        check_eq("t4_stall_ready", 64'(o_ready), 64'h0);
        i_pop_TaskFIFO = 4'b0001;
        cyc();
        i_pop_TaskFIFO = '0;
        check_eq("t4_freed_ready", 64'(o_ready), 64'h1);
        check_eq("t4_head0", 64'(o_TaskFIFO_data[0]), 64'(mk(1'b1, 2'd0, 32'd0)));
        cyc();
        i_valid = 1'b0;
        check_eq("t4_next_ready", 64'(o_ready), 64'h0);
        for (int k = 1; k <= 4; k++) begin
            do_pop(0);
            exp_e = (k == 4) ? mk(1'b1, 2'd0, 32'h11) : mk(1'b1, 2'(k), 32'(4 * k));
            check_eq($sformatf("t4_f0_%0d", k), 64'(o_TaskFIFO_data[0]), 64'(exp_e));
        end
        check_eq("t4_f0_empty", 64'(o_TaskFIFO_empty[0]), 64'h1);

        // 5: simultaneous write and read on FIFO2 holding one entry
        do_reset("t5");
        for (int k = 0; k < 6; k++) begin
            do_req(1'b1, 2'd0, 32'(32'hA + k));
        end
        i_valid = 1'b1;
        i_type = 1'b1;
        i_tree_id = 2'd0;
        i_push_data = 32'h99;
        i_pop_TaskFIFO = 4'b0100;
        cyc();
        i_valid = 1'b0;
        i_pop_TaskFIFO = '0;
        check_eq("t5_old", 64'(o_TaskFIFO_data[2]), 64'(mk(1'b1, 2'd0, 32'hC)));
        check_eq("t5_nonempty", 64'(o_TaskFIFO_empty[2]), 64'h0);
        do_pop(2);
        check_eq("t5_new", 64'(o_TaskFIFO_data[2]), 64'(mk(1'b1, 2'd0, 32'h99)));
        check_eq("t5_empty", 64'(o_TaskFIFO_empty[2]), 64'h1);
        do_pop(2);
        check_eq("t5_hold", 64'(o_TaskFIFO_data[2]), 64'(mk(1'b1, 2'd0, 32'h99)));

        // 6: tree capacity
        do_reset("t6");
        for (int k = 0; k < 8; k++) begin
            do_req(1'b1, 2'd0, 32'(k));
            check_eq($sformatf("t6_nodrop%0d", k), 64'(o_drop), 64'h0);
        end
        do_req(1'b1, 2'd0, 32'h9);
`ifdef TASK_FIFO_BANK_TREE_CHECK_EN
        check_eq("t6_drop9", 64'(o_drop), 64'h1);
        exp_e = mk(1'b0, 2'd0, 32'h0);
`else
        check_eq("t6_drop9", 64'(o_drop), 64'h0);
        exp_e = mk(1'b1, 2'd0, 32'h9);
`endif
        do_req(1'b0, 2'd0, 32'hBEEF);
        check_eq("t6_pop_drop", 64'(o_drop), 64'h0);
        do_req(1'b1, 2'd0, 32'h77);
        check_eq("t6_push_drop", 64'(o_drop), 64'h0);
        do_pop(0);
        check_eq("t6_f0_a", 64'(o_TaskFIFO_data[0]), 64'(mk(1'b1, 2'd0, 32'h0)));
        do_pop(0);
        check_eq("t6_f0_b", 64'(o_TaskFIFO_data[0]), 64'(mk(1'b1, 2'd0, 32'h4)));
        do_pop(0);
        check_eq("t6_f0_c", 64'(o_TaskFIFO_data[0]), 64'(exp_e));
        check_eq("t6_f0_empty", 64'(o_TaskFIFO_empty[0]), 64'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/task_fifo_bank.md
# task_fifo_bank

Write side of the per-level task FIFOs feeding the vPIFO task distributor. Accepts one push/pop request per cycle from the host, tagged with a tree ID, and packs it into the task-entry format. Entries are dealt round-robin across LEVEL internal FIFOs. The read side is exposed with the pop / data / empty handshake the distributor consumes. An optional per-tree occupancy check drops illegal requests before they enter the tree pipeline.

## Interface
- PTW, 16, payload width
- MTW, 16, metadata width
- LEVEL, 4, RPU / FIFO count; LEVEL_BITS = $clog2(LEVEL)
- TREE_NUM, 4, virtual trees; TREE_NUM_BITS = $clog2(TREE_NUM)
- FIFO_DEPTH, 4, entries per FIFO, power of two
- TREE_CAP, 8, max outstanding elements per tree (used only with check enabled)

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid
- i_type  in  1  1 = push, 0 = pop
- i_tree_id  in  TREE_NUM_BITS  target tree
- i_push_data  in  PTW+MTW  push payload; ignored for pop
- o_ready  out  1  request accepted when i_valid && o_ready
- o_drop  out  1  one-cycle pulse: previous accepted request was discarded
- i_pop_TaskFIFO  in  LEVEL  per-FIFO read strobe
- o_TaskFIFO_data  out  [PTW+MTW+TREE_NUM_BITS:0] x LEVEL  {type, treeId, data}
- o_TaskFIFO_empty  out  LEVEL  per-FIFO empty flag

## Operation
- Entry format is {i_type, i_tree_id, payload}. Payload is forced to 0 for pops.
- A 2-bit-wide round-robin pointer rr_ptr (LEVEL_BITS wide) selects the target FIFO.
  - An accepted, non-dropped request writes FIFO[rr_ptr].
  - rr_ptr then increments, wrapping LEVEL-1 -> 0.
- o_ready = !full[rr_ptr]. There is no skipping to other FIFOs: a full target stalls the host, so the deal order stays strictly deterministic.
- Each FIFO keeps a count, and pointers that wrap at FIFO_DEPTH.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - Simultaneous write and read on the same FIFO leaves count unchanged.
  - Data order is preserved, including the case count == 1 with both strobes active.
- A read strobe on an empty FIFO is ignored: pointers and o_TaskFIFO_data hold.
- Tree check (when compiled in):
  - Per-tree counter, width $clog2(TREE_CAP+1).
  - An accepted push with tree_cnt == TREE_CAP is dropped.
  - An accepted pop with tree_cnt == 0 is dropped.
  - Otherwise an accepted push increments and an accepted pop decrements the counter.
  - A dropped request is still consumed (handshake completes). It does not write a FIFO and does not advance rr_ptr.
- Reset mid-operation clears all FIFO contents, counts, tree counters and rr_ptr immediately.

## Timing
- Reset values: o_ready 0, o_drop 0, o_TaskFIFO_empty all 1, o_TaskFIFO_data all 0, rr_ptr 0.
- o_ready is combinational from registered state. Its first assertion is the cycle after reset release.
- Write latency: an entry accepted at edge N clears o_TaskFIFO_empty after edge N (visible in cycle N+1).
- Read: i_pop_TaskFIFO[i] high in cycle N while empty[i] = 0 → the head entry appears on o_TaskFIFO_data[i] in cycle N+1 (registered read) and holds until the next effective pop.
- empty is sampled by the consumer in the pop cycle; no combinational path from i_pop to empty.
- full deasserts the cycle after the read that frees a slot. o_ready follows in that same cycle.
- o_drop pulses in cycle N+1 for a request dropped at edge N.

## Configuration
- TASK_FIFO_BANK_TREE_CHECK_EN defined: tree counters and drop logic are present.
- Undefined:
  - No tree counters.
  - Every accepted request is written.
  - o_drop is tied to 0.
  - TREE_CAP is unused.

## Structure
- Shared package (vpifo_pkg) holds:
  - TASK_PUSH = 1'b1 and TASK_POP = 1'b0;
  - the task entry width function / localparam PTW+MTW+TREE_NUM_BITS+1;
  - the entry field offsets, identical to those the distributor decodes.
- One sub-module: task_fifo, a synchronous FIFO with registered read data and count-based full/empty flags. It is instantiated LEVEL times by generate.

## Test plan
1. Defaults, check enabled: assert reset → o_TaskFIFO_empty = 4'b1111, o_ready = 0. Release → o_ready = 1 next cycle.
2. Pushes tree 2, data 0x0001..0x0004, back-to-back → one per FIFO 0..3, all empty = 0. Pop FIFO1 → next cycle data = {1'b1, 2'd2, 32'h0000_0002}.
3. Pop on tree 3 with count 0 → o_drop = 1 one cycle later, no empty flag changes, rr_ptr unchanged. The next push lands in the same FIFO.
4. 16 pushes spread over trees 0–3 (4 each), no reads → all FIFOs full and o_ready = 0 on the 17th. Pop FIFO0 → o_ready = 1 the following cycle, and the 17th entry is written to FIFO0.
5. FIFO2 holding one entry, pop and write in the same cycle → count stays 1. The read returns the old entry, and the next pop returns the new one.
6. 8 pushes tree 0 accepted, 9th → o_drop. One pop on tree 0 is accepted; a following push is then accepted with no drop. With the macro undefined, the 9th push is written and o_drop stays 0.
